// File: rtl/pwm_axil_regs.sv
// AXI4-Lite control/status register bank for the AXI-Stream PWM generator.
// Define PWM_AXIL_SLVERR_EN to answer RO/unmapped accesses with SLVERR.
module pwm_axil_regs #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]   cfg_reg0,
  output logic [DATA_WIDTH-1:0]   cfg_reg1,
  output logic [DATA_WIDTH-1:0]   cfg_reg2,
  output logic [DATA_WIDTH-1:0]   cfg_reg3,
  output logic [3:0]              cfg_wr_pulse,
  input  logic [DATA_WIDTH-1:0]   status_in
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef PWM_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_ERR = 2'b10;
`else
  localparam logic [1:0] RESP_ERR = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] regs [4];
  logic [DATA_WIDTH-1:0] rd_value;
  logic [2:0]            wr_word;
  logic [2:0]            rd_word;
  logic                  unused;

  function automatic logic [DATA_WIDTH-1:0] apply_strb(input logic [DATA_WIDTH-1:0] cur,
                                                       input logic [DATA_WIDTH-1:0] nxt,
                                                       input logic [NB-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    res = cur;
    for (int k = 0; k < NB; k++)
      if (strb[k]) res[8*k +: 8] = nxt[8*k +: 8];
    return res;
  endfunction

  // Status word is read-only, so a write to it is an error when errors are enabled.
  function automatic logic [1:0] wr_resp(input logic [2:0] word);
    return (word >= 3'd4) ? RESP_ERR : RESP_OKAY;
  endfunction

  function automatic logic [1:0] rd_resp(input logic [2:0] word);
    return (word >= 3'd5) ? RESP_ERR : RESP_OKAY;
  endfunction

  assign wr_word = S_AXI_AWADDR[4:2];
  assign rd_word = S_AXI_ARADDR[4:2];
  assign unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = (w_state == W_ACK);
  assign S_AXI_WREADY  = (w_state == W_ACK);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_ARREADY = (r_state == R_ACK);
  assign S_AXI_RVALID  = (r_state == R_DATA);

  assign cfg_reg0 = regs[0];
  assign cfg_reg1 = regs[1];
  assign cfg_reg2 = regs[2];
  assign cfg_reg3 = regs[3];

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) w_next = W_ACK;
      W_ACK:   w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (S_AXI_ARVALID && !S_AXI_RVALID) r_next = R_ACK;
      R_ACK:   r_next = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Commit happens on the edge that closes the AW/W handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      cfg_wr_pulse <= '0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      cfg_wr_pulse <= '0;
      if (w_state == W_ACK) begin
        if (!wr_word[2]) begin
          regs[wr_word[1:0]]         <= apply_strb(regs[wr_word[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
          cfg_wr_pulse[wr_word[1:0]] <= 1'b1;
        end
        S_AXI_BRESP <= wr_resp(wr_word);
      end
    end
  end

  always_comb begin
    rd_value = '0;
    case (rd_word)
      3'd0:    rd_value = regs[0];
      3'd1:    rd_value = regs[1];
      3'd2:    rd_value = regs[2];
      3'd3:    rd_value = regs[3];
      3'd4:    rd_value = status_in;
      default: rd_value = '0;
    endcase
  end

  // Captured from pre-commit register contents when a write lands on the same edge.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (r_state == R_ACK) begin
      S_AXI_RDATA <= rd_value;
      S_AXI_RRESP <= rd_resp(rd_word);
    end
  end

endmodule

// File: tb/tb_pwm_axil_regs.sv
// Directed self-checking bench for pwm_axil_regs.
module tb_pwm_axil_regs;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, status_in;
  logic [3:0]  wstrb, cfg_wr_pulse;
  logic [1:0]  bresp, rresp;
  logic [31:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0]  resp;
  logic [3:0]  pulse;
  logic [31:0] data;
  logic        flag_a, flag_b;

`ifdef PWM_AXIL_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  always #5 clk = ~clk;

  pwm_axil_regs #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_reg0(cfg_reg0), .cfg_reg1(cfg_reg1), .cfg_reg2(cfg_reg2), .cfg_reg3(cfg_reg3),
    .cfg_wr_pulse(cfg_wr_pulse), .status_in(status_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] strb,
                           output logic [1:0] r, output logic [3:0] p);
    int n;
    awaddr = addr; wdata = d; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(awready && wready) && n < 20);
    if (!(awready && wready)) check("wr_ready_timeout", {31'd0, awready && wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) check("wr_bvalid_timeout", {31'd0, bvalid}, 32'd1);
    r = bresp; p = cfg_wr_pulse;
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arready && n < 20);
    if (!arready) check("rd_ready_timeout", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) check("rd_rvalid_timeout", {31'd0, rvalid}, 32'd1);
    d = rdata; r = rresp;
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  initial begin
    logic [31:0] wvals [4];
    wvals[0] = 32'h0101FFFF; wvals[1] = 32'hABCD0001;
    wvals[2] = 32'hDEAD0011; wvals[3] = 32'hBEEF0011;

    aresetn = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status_in = 32'h00000FA5;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    check("rst_cfg", cfg_reg0 | cfg_reg1 | cfg_reg2 | cfg_reg3, 32'h0);
    check("rst_hs", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_pulse", {28'd0, cfg_wr_pulse}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), wvals[i], 4'hF, resp, pulse);
      check($sformatf("wr%0d_bresp", i), {30'd0, resp}, 32'h0);
      check($sformatf("wr%0d_pulse", i), {28'd0, pulse}, 32'(1 << i));
    end
    check("pulse_one_cycle", {28'd0, cfg_wr_pulse}, 32'h0);
    check("cfg_reg0", cfg_reg0, wvals[0]);
    check("cfg_reg1", cfg_reg1, wvals[1]);
    check("cfg_reg2", cfg_reg2, wvals[2]);
    check("cfg_reg3", cfg_reg3, wvals[3]);
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), data, resp);
      check($sformatf("rd%0d_data", i), data, wvals[i]);
      check($sformatf("rd%0d_rresp", i), {30'd0, resp}, 32'h0);
    end

    axi_write(5'h04, 32'h11223344, 4'b0101, resp, pulse);
    axi_read(5'h04, data, resp);
    check("strb_0101", data, 32'hAB220044);

    axi_write(5'h08, 32'hFFFFFFFF, 4'b0000, resp, pulse);
    check("strb0_pulse", {28'd0, pulse}, 32'h4);
    check("strb0_bresp", {30'd0, resp}, 32'h0);
    check("strb0_keep", cfg_reg2, 32'hDEAD0011);

    axi_read(5'h10, data, resp);
    check("status_data", data, 32'h00000FA5);
    check("status_rresp", {30'd0, resp}, 32'h0);
    axi_write(5'h10, 32'h12345678, 4'hF, resp, pulse);
    check("ro_bresp", {30'd0, resp}, {30'd0, EXP_ERR});
    check("ro_pulse", {28'd0, pulse}, 32'h0);
    axi_read(5'h10, data, resp);
    check("ro_unchanged", data, 32'h00000FA5);
    axi_read(5'h14, data, resp);
    check("unmap_rdata", data, 32'h0);
    check("unmap_rresp", {30'd0, resp}, {30'd0, EXP_ERR});
    axi_write(5'h1C, 32'h87654321, 4'hF, resp, pulse);
    check("unmap_bresp", {30'd0, resp}, {30'd0, EXP_ERR});
    check("unmap_pulse", {28'd0, pulse}, 32'h0);
    check("unmap_regs", cfg_reg0 ^ cfg_reg1 ^ cfg_reg2 ^ cfg_reg3,
          32'h0101FFFF ^ 32'hAB220044 ^ 32'hDEAD0011 ^ 32'hBEEF0011);

    // AW arrives five cycles before W; then B is held off while a second write waits.
    awaddr = 5'h00; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1'b1;
    flag_a = 1'b0;
    repeat (5) begin tick(); if (awready || wready) flag_a = 1'b1; end
    check("aw_only_no_ready", {31'd0, flag_a}, 32'h0);
    wvalid = 1'b1;
    tick();
    check("aw_w_ready", {30'd0, awready, wready}, 32'h3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("late_bvalid", {31'd0, bvalid}, 32'h1);
    check("late_commit", cfg_reg0, 32'h11111111);
    awaddr = 5'h04; wdata = 32'h22222222; awvalid = 1'b1; wvalid = 1'b1;
    flag_a = 1'b0; flag_b = 1'b0;
    repeat (10) begin tick(); if (!bvalid) flag_a = 1'b1; if (awready) flag_b = 1'b1; end
    check("bvalid_held", {31'd0, flag_a}, 32'h0);
    check("second_wr_blocked", {31'd0, flag_b}, 32'h0);
    check("second_wr_nocommit", cfg_reg1, 32'hAB220044);
    bready = 1'b1; tick(); bready = 1'b0;
    check("after_b_idle", {30'd0, bvalid, awready}, 32'h0);
    tick();
    check("second_wr_ready", {31'd0, awready}, 32'h1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("second_wr_commit", cfg_reg1, 32'h22222222);
    bready = 1'b1; tick(); bready = 1'b0;

    // Write and read of the same word launched on the same edge.
    awaddr = 5'h04; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    tick();
    check("conc_readies", {30'd0, awready, arready}, 32'h3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("conc_valids", {30'd0, bvalid, rvalid}, 32'h3);
    check("conc_old_rdata", rdata, 32'h22222222);
    check("conc_new_reg", cfg_reg1, 32'h5A5A5A5A);
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
    axi_read(5'h04, data, resp);
    check("conc_reread", data, 32'h5A5A5A5A);

    // Reset while a write response is pending.
    awaddr = 5'h08; wdata = 32'h12345678; awvalid = 1'b1; wvalid = 1'b1;
    tick(); tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_bvalid", {31'd0, bvalid}, 32'h1);
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    check("mid_rst_bvalid", {31'd0, bvalid}, 32'h0);
    check("mid_rst_cfg", cfg_reg0 | cfg_reg1 | cfg_reg2 | cfg_reg3, 32'h0);
    check("mid_rst_pulse", {28'd0, cfg_wr_pulse}, 32'h0);
    axi_write(5'h0C, 32'hCAFEF00D, 4'hF, resp, pulse);
    check("post_rst_bresp", {30'd0, resp}, 32'h0);
    check("post_rst_pulse", {28'd0, pulse}, 32'h8);
    check("post_rst_cfg3", cfg_reg3, 32'hCAFEF00D);
    axi_read(5'h0C, data, resp);
    check("post_rst_read", data, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
